// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line blocks.
// Contents:
//   RESP_*        resp_type encodings for the response receiver
//   LEN_SHORT/LONG  response frame lengths in bits
//   CRC7_POLY     CRC7 polynomial x^7 + x^3 + 1 (implicit x^7)
//   rx_state_t    receiver FSM states
//   crc7_step     one serial CRC7 update
package sd_pkg;

  localparam logic [1:0] RESP_SHORT       = 2'd0;
  localparam logic [1:0] RESP_SHORT_NOCRC = 2'd1;
  localparam logic [1:0] RESP_LONG        = 2'd2;
  localparam logic [1:0] RESP_SHORT_BUSY  = 2'd3;

  localparam int unsigned LEN_SHORT = 48;
  localparam int unsigned LEN_LONG  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECEIVE,
    ST_WAIT_BUSY
  } rx_state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB first.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         restart from 0; combined with en the bit is fed into the fresh CRC
//   en            feed bit_in this cycle
//   bit_in        serial data bit
//   crc           current remainder
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= en ? crc7_step(7'h00, bit_in) : 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_resp_rx_ctrl.sv
// SD command-line response receiver (R1/R1b/R2/R3/R6/R7).
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start, resp_type    request a reception of the given response class (IDLE only)
//   abort               drop back to IDLE without done
//   sample_en           SD clock rising-edge strobe qualifying sd_cmd / sd_dat0
//   sd_cmd, sd_dat0     serial response line, busy line (low = busy)
//   response            received frame, right-aligned (short in [47:0])
//   started, busy, done status; done is a one-cycle pulse
//   crc_err, frame_err, timeout_err  result flags, held until next accepted start
module sd_resp_rx_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX  = 64,
  parameter int unsigned BUSY_MAX = 65535,
  parameter bit          CRC_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   resp_type,
  input  logic         abort,
  input  logic         sample_en,
  input  logic         sd_cmd,
  input  logic         sd_dat0,
  output logic [135:0] response,
  output logic         started,
  output logic         busy,
  output logic         done,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout_err
);

  localparam int unsigned NCR_W  = $clog2(NCR_MAX + 1);
  localparam int unsigned BUSY_W = $clog2(BUSY_MAX + 1);
  localparam logic [NCR_W-1:0]  NCR_LAST  = NCR_W'(NCR_MAX - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX - 1);
  localparam logic [BUSY_W-1:0] BUSY_SKIP = BUSY_W'(2);

  rx_state_t          state, state_next;
  logic [1:0]         rtype;
  logic [7:0]         bit_cnt;
  logic [NCR_W-1:0]   wait_cnt;
  logic [BUSY_W-1:0]  busy_cnt;
  logic [6:0]         crc;
  logic [7:0]         tx_pos;

  logic accept, got_start, rx_bit, finish, timeout;
  logic ncr_inc, busy_inc, crc_clear, crc_en;

  assign busy   = (state != ST_IDLE);
  assign tx_pos = (rtype == RESP_LONG) ? 8'(LEN_LONG - 2) : 8'(LEN_SHORT - 2);

  crc7_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .en      (crc_en),
    .bit_in  (sd_cmd),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    got_start  = 1'b0;
    rx_bit     = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    ncr_inc    = 1'b0;
    busy_inc   = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            accept     = 1'b1;
            state_next = ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (sample_en) begin
            if (!sd_cmd) begin
              got_start  = 1'b1;
              crc_clear  = 1'b1;
              // R2 start/transmission/reserved bits are outside its CRC
              crc_en     = (rtype != RESP_LONG);
              state_next = ST_RECEIVE;
            end else if (wait_cnt >= NCR_LAST) begin
              timeout    = 1'b1;
              finish     = 1'b1;
              state_next = ST_IDLE;
            end else begin
              ncr_inc = 1'b1;
            end
          end
        end
        ST_RECEIVE: begin
          if (sample_en) begin
            rx_bit = 1'b1;
            crc_en = (bit_cnt >= 8'd8) && ((rtype != RESP_LONG) || (bit_cnt <= 8'd127));
            if (bit_cnt == 8'd0) begin
              if (rtype == RESP_SHORT_BUSY) begin
                state_next = ST_WAIT_BUSY;
              end else begin
                finish     = 1'b1;
                state_next = ST_IDLE;
              end
            end
          end
        end
        ST_WAIT_BUSY: begin
          if (sample_en) begin
            if (busy_cnt < BUSY_SKIP) begin
              busy_inc = 1'b1;
            end else if (sd_dat0) begin
              finish     = 1'b1;
              state_next = ST_IDLE;
            end else if (busy_cnt >= BUSY_LAST) begin
              timeout    = 1'b1;
              finish     = 1'b1;
              state_next = ST_IDLE;
            end else begin
              busy_inc = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rtype       <= RESP_SHORT;
      response    <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      busy_cnt    <= '0;
      started     <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        rtype       <= resp_type;
        response    <= '0;
        bit_cnt     <= (resp_type == RESP_LONG) ? 8'(LEN_LONG - 1) : 8'(LEN_SHORT - 1);
        wait_cnt    <= '0;
        busy_cnt    <= '0;
        started     <= 1'b0;
        crc_err     <= 1'b0;
        frame_err   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (got_start) begin
        response[bit_cnt] <= sd_cmd;
        bit_cnt           <= bit_cnt - 8'd1;
        started           <= 1'b1;
      end
      if (rx_bit) begin
        response[bit_cnt] <= sd_cmd;
        if (bit_cnt != 8'd0) bit_cnt <= bit_cnt - 8'd1;
        if ((bit_cnt == tx_pos) && sd_cmd) frame_err <= 1'b1;
        if (bit_cnt == 8'd0) begin
          if (!sd_cmd) frame_err <= 1'b1;
          // bits [7:1] are already stored by the time the end bit arrives
          if (CRC_EN && (rtype != RESP_SHORT_NOCRC) && (crc != response[7:1]))
            crc_err <= 1'b1;
        end
      end
      if (ncr_inc && (wait_cnt != '1)) wait_cnt <= wait_cnt + NCR_W'(1);
      if (busy_inc && (busy_cnt != '1)) busy_cnt <= busy_cnt + BUSY_W'(1);
      if (timeout) timeout_err <= 1'b1;
      if (finish || abort) started <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_resp_rx_ctrl.sv
module tb_sd_resp_rx_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   resp_type;
  logic         abort;
  logic         sample_en;
  logic         sd_cmd;
  logic         sd_dat0;
  logic [135:0] response;
  logic         started;
  logic         busy;
  logic         done;
  logic         crc_err;
  logic         frame_err;
  logic         timeout_err;

  int vec = 0;
  int err = 0;
  int done_cnt = 0;
  logic started_seen = 1'b0;

  localparam logic [47:0]  F_R7  = 48'h08000001AA13;
  localparam logic [47:0]  F_R3  = 48'h3F80FF8000FF;
  localparam logic [119:0] R2_PL = 120'h1D414453414D504C450123456789AB;

  always #5 clk = ~clk;

  sd_resp_rx_ctrl #(
    .NCR_MAX  (64),
    .BUSY_MAX (65535),
    .CRC_EN   (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .resp_type   (resp_type),
    .abort       (abort),
    .sample_en   (sample_en),
    .sd_cmd      (sd_cmd),
    .sd_dat0     (sd_dat0),
    .response    (response),
    .started     (started),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (started === 1'b1) started_seen <= 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vec, err + 1);
    $fatal(1, "watchdog");
  end

  // Remainder of msg * x^7 divided by x^7 + x^3 + 1 (long division form).
  function automatic logic [6:0] crc7_ref(input logic [127:0] msg);
    logic [134:0] m;
    m = {msg, 7'b0};
    for (int i = 134; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  task automatic do_start(input logic [1:0] t);
    @(negedge clk);
    start = 1'b1;
    resp_type = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sd_cmd = b;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    sd_cmd = 1'b1;
  endtask

  task automatic strobe_busy(input logic d);
    @(negedge clk);
    sd_dat0 = d;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic send_frame(input logic [135:0] f, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic run_frame(input logic [1:0] t, input logic [135:0] f, input int len);
    do_start(t);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_frame(f, len);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; resp_type = 2'd0; abort = 1'b0;
    sample_en = 1'b0; sd_cmd = 1'b1; sd_dat0 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vec++; if (response !== 136'h0) begin err++; $display("FAIL reset_response: got %h want 0", response); end
    vec++; if ({started, busy, done} !== 3'b000) begin err++; $display("FAIL reset_status: got %b want 000", {started, busy, done}); end
    vec++; if ({crc_err, frame_err, timeout_err} !== 3'b000) begin err++; $display("FAIL reset_flags: got %b want 000", {crc_err, frame_err, timeout_err}); end
  endtask

  task automatic test_short_crc();
    int d0;
    d0 = done_cnt;
    started_seen = 1'b0;
    do_start(2'd0);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL r7_busy_after_start: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_frame({88'h0, F_R7}, 48);
    vec++; if (done !== 1'b1) begin err++; $display("FAIL r7_done: got %b want 1", done); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL r7_busy_with_done: got %b want 0", busy); end
    vec++; if (response !== {88'h0, F_R7}) begin err++; $display("FAIL r7_response: got %h want %h", response, {88'h0, F_R7}); end
    vec++; if ({crc_err, frame_err, timeout_err} !== 3'b000) begin err++; $display("FAIL r7_flags: got %b want 000", {crc_err, frame_err, timeout_err}); end
    vec++; if ({started, started_seen} !== 2'b01) begin err++; $display("FAIL r7_started: got %b want 01", {started, started_seen}); end
    @(negedge clk);
    vec++; if (done !== 1'b0 || done_cnt != d0 + 1) begin err++; $display("FAIL r7_done_pulse: got done %b count %0d want 0 %0d", done, done_cnt, d0 + 1); end
  endtask

  task automatic test_crc_error();
    logic [47:0] bad;
    bad = F_R7 ^ 48'h000000100000;
    run_frame(2'd0, {88'h0, bad}, 48);
    vec++; if ({done, crc_err, frame_err} !== 3'b110) begin err++; $display("FAIL crc_bad_t0: got done/crc/frame %b want 110", {done, crc_err, frame_err}); end
    run_frame(2'd1, {88'h0, bad}, 48);
    vec++; if ({done, crc_err, frame_err} !== 3'b100) begin err++; $display("FAIL crc_bad_t1: got done/crc/frame %b want 100", {done, crc_err, frame_err}); end
  endtask

  task automatic test_r3();
    logic [47:0] bad;
    run_frame(2'd1, {88'h0, F_R3}, 48);
    vec++; if ({done, crc_err, frame_err, timeout_err} !== 4'b1000) begin err++; $display("FAIL r3_clean: got done/crc/frame/to %b want 1000", {done, crc_err, frame_err, timeout_err}); end
    vec++; if (response !== {88'h0, F_R3}) begin err++; $display("FAIL r3_response: got %h want %h", response, {88'h0, F_R3}); end
    bad = F_R3 ^ 48'h1;
    run_frame(2'd1, {88'h0, bad}, 48);
    vec++; if ({done, crc_err, frame_err} !== 3'b101) begin err++; $display("FAIL r3_endbit: got done/crc/frame %b want 101", {done, crc_err, frame_err}); end
  endtask

  task automatic test_long();
    logic [135:0] f;
    f = {8'h3F, R2_PL, crc7_ref({8'h00, R2_PL}), 1'b1};
    run_frame(2'd2, f, 136);
    vec++; if ({done, crc_err, frame_err} !== 3'b100) begin err++; $display("FAIL r2_clean: got done/crc/frame %b want 100", {done, crc_err, frame_err}); end
    vec++; if (response !== f) begin err++; $display("FAIL r2_response: got %h want %h", response, f); end
    f[130] = ~f[130];
    run_frame(2'd2, f, 136);
    vec++; if ({done, crc_err, frame_err} !== 3'b100) begin err++; $display("FAIL r2_bit130: got done/crc/frame %b want 100", {done, crc_err, frame_err}); end
    vec++; if (response !== f) begin err++; $display("FAIL r2_bit130_response: got %h want %h", response, f); end
  endtask

  task automatic test_timeout();
    started_seen = 1'b0;
    do_start(2'd0);
    for (int i = 0; i < 64; i++) begin
      send_bit(1'b1);
      if (i == 62) begin
        vec++; if (done !== 1'b0) begin err++; $display("FAIL ncr_63_strobes: got done %b want 0", done); end
      end
    end
    vec++; if ({done, timeout_err, crc_err, frame_err} !== 4'b1100) begin err++; $display("FAIL ncr_timeout: got done/to/crc/frame %b want 1100", {done, timeout_err, crc_err, frame_err}); end
    vec++; if (started_seen !== 1'b0) begin err++; $display("FAIL ncr_started: got %b want 0", started_seen); end
  endtask

  task automatic test_busy();
    run_frame(2'd3, {88'h0, F_R7}, 48);
    vec++; if ({done, busy} !== 2'b01) begin err++; $display("FAIL r1b_frame_end: got done/busy %b want 01", {done, busy}); end
    for (int i = 0; i < 100; i++) strobe_busy(1'b0);
    vec++; if ({done, busy} !== 2'b01) begin err++; $display("FAIL r1b_held: got done/busy %b want 01", {done, busy}); end
    strobe_busy(1'b1);
    vec++; if ({done, busy, crc_err, frame_err, timeout_err} !== 5'b10000) begin err++; $display("FAIL r1b_release: got done/busy/crc/frame/to %b want 10000", {done, busy, crc_err, frame_err, timeout_err}); end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin err++; $display("FAIL r1b_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_abort();
    int d0;
    logic [47:0] part;
    d0 = done_cnt;
    do_start(2'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    for (int i = 47; i >= 31; i--) send_bit(F_R7[i]);
    @(negedge clk);
    abort = 1'b1; start = 1'b1; resp_type = 2'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL abort_idle: got busy %b want 0", busy); end
    repeat (4) @(negedge clk);
    vec++; if (done_cnt != d0 || busy !== 1'b0) begin err++; $display("FAIL abort_no_done: got count %0d busy %b want %0d 0", done_cnt, busy, d0); end
    part = F_R7 & 48'hFFFF80000000;
    vec++; if (response !== {88'h0, part}) begin err++; $display("FAIL abort_partial: got %h want %h", response, {88'h0, part}); end
    run_frame(2'd0, {88'h0, F_R7}, 48);
    vec++; if ({done, crc_err, frame_err, timeout_err} !== 4'b1000 || response !== {88'h0, F_R7}) begin err++; $display("FAIL abort_recover: got flags %b resp %h want 1000 %h", {done, crc_err, frame_err, timeout_err}, response, {88'h0, F_R7}); end
  endtask

  task automatic test_reset_mid();
    logic [135:0] f;
    f = {8'h3F, R2_PL, crc7_ref({8'h00, R2_PL}), 1'b1};
    do_start(2'd2);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    for (int i = 135; i >= 116; i--) send_bit(f[i]);
    vec++; if ({started, busy} !== 2'b11) begin err++; $display("FAIL midframe_status: got started/busy %b want 11", {started, busy}); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vec++; if ({response, started, busy, done, crc_err, frame_err, timeout_err} !== 142'h0) begin err++; $display("FAIL midframe_reset: got resp %h status %b want all 0", response, {started, busy, done, crc_err, frame_err, timeout_err}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_short_crc();
    test_crc_error();
    test_r3();
    test_long();
    test_timeout();
    test_busy();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/sd_resp_rx_ctrl.md
# sd_resp_rx_ctrl

Parametrised SD command-line response receiver. Runs on one system clock and samples `sd_cmd` on a single-cycle `sample_en` strobe (SD clock rising edge, generated upstream). Handles all response classes with serial on-the-fly CRC7:
- short with CRC (R1/R6/R7)
- short without CRC (R3)
- long R2
- short with busy (R1b, monitors `sd_dat0`)

It adds N_CR start-bit timeout, framing checks and abort. It sits between the command sequencer and the pad interface.

## Interface
- `NCR_MAX`, 64: max `sample_en` strobes waiting for the start bit before `timeout_err`.
- `BUSY_MAX`, 65535: max strobes `sd_dat0` may stay low in R1b busy before `timeout_err`.
- `CRC_EN`, 1: 0 disables CRC checking globally (`crc_err` stays 0).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `resp_type`  in  2  sampled with `start`: 0 = short+CRC, 1 = short no CRC, 2 = long R2, 3 = short+CRC+busy.
- `abort`  in  1  return to IDLE, no `done`.
- `sample_en`  in  1  strobe; `sd_cmd`/`sd_dat0` are used only when high.
- `sd_cmd`  in  1  serial response, MSB first.
- `sd_dat0`  in  1  busy line, low = busy.
- `response`  out  136  received frame, right-aligned: short in [47:0] with [135:48] = 0, long in [135:0].
- `started`  out  1  high from start-bit detection until `done`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `crc_err`, `frame_err`, `timeout_err`  out  1 each  status; valid with `done` and held until the next accepted `start`.

## Operation
States: IDLE → WAIT_START → RECEIVE → (WAIT_BUSY) → IDLE.

**IDLE**
- `start` & !`abort`: latch `resp_type`, clear `response` and error flags, clear counters → WAIT_START.
- Frame length L = 136 for type 2, else 48.

**WAIT_START**
- On each strobe, if `sd_cmd` = 0: store bit at position L-1, set `started`, reset the CRC to 0, feed the bit → RECEIVE.
- Otherwise increment the wait counter. Reaching `NCR_MAX` strobes without a start bit: `timeout_err` = 1, `done`, → IDLE.

**RECEIVE**
- Each strobe shifts `sd_cmd` into `response`; a bit counter tracks frame position p from L-2 down to 0.
- Transmission bit (p = L-2) must be 0; else `frame_err`.
- CRC7 (poly x^7+x^3+1, init 0):
  - Types 0/1/3: fed bits 47..8, start bit included.
  - Type 2: fed bits 127..8 only; bits 135..128 are excluded.
- After p = 8, the computed CRC is frozen and compared with received bits [7:1]. A mismatch sets `crc_err` only if `CRC_EN` = 1 and type ≠ 1.
- End bit (p = 0) must be 1; else `frame_err`.
- After the end bit: type 3 → WAIT_BUSY; other types → `done`, → IDLE.
- Errors never truncate reception; the full frame is always received.

**WAIT_BUSY**
- The first 2 strobes are ignored (busy onset window).
- Thereafter, the first strobe with `sd_dat0` = 1 → `done`, → IDLE.
- `BUSY_MAX` strobes without release → `timeout_err`, `done`, → IDLE.

**Abort and concurrency**
- `abort` in any state: IDLE next cycle. `response` keeps its partial contents, no `done`, error flags unchanged. `abort` wins over simultaneous `start`.
- `start` while not IDLE is ignored.

## Timing
- Reset values: `response` = 0, `started` = 0, `busy` = 0, `done` = 0, all error flags 0, state IDLE. Reset mid-frame clears everything immediately.
- `start` accepted at edge N: `busy` = 1 from N+1. A `sample_en` coincident with `start` is not used; the first usable strobe is at N+1 or later.
- `done` is registered: high exactly one cycle, in the cycle after the edge that processed the final strobe (end bit, busy release, or timeout). `response` and flags are already final when `done` is high.
- `busy` drops in the same cycle `done` rises, so a new `start` can be accepted while `done` is high.
- Counter widths are $clog2(`NCR_MAX`+1) and $clog2(`BUSY_MAX`+1); counters saturate and do not wrap.

## Structure
- Shared package `sd_pkg`:
  - resp_type encoding constants (`RESP_SHORT`, `RESP_SHORT_NOCRC`, `RESP_LONG`, `RESP_SHORT_BUSY`)
  - frame lengths 48/136
  - CRC7 polynomial 7'h09
  - state encoding
- Sub-module `crc7_serial` (clk, reset_n, clear, en, bit_in, crc[6:0]), reusable by the command transmitter.

## Test plan
- Type 0, frame 48'h08000001AA13, clean line → `done` after 48 data strobes, `response`[47:0] = 48'h08000001AA13, all flags 0.
- Same frame with bit 20 flipped → `crc_err` = 1, `frame_err` = 0. Repeat with type 1 → `crc_err` = 0.
- Type 1, R3 frame 48'h3F80FF8000FF → `done`, no errors. Same frame with end bit 0 → `frame_err` = 1.
- Type 2 R2 frame with valid CRC over bits 127..8 → `response` = frame, `crc_err` = 0. Corrupt bit 130 (excluded from CRC) → `crc_err` still 0.
- Type 0, `sd_cmd` held high for 64 strobes → `timeout_err` = 1, `started` never set. Type 3 with `sd_dat0` low 100 strobes → `done` one cycle after the first high sample.
- Abort at bit 30 of a frame, then `start` in the same cycle as `abort` → no `done`, IDLE. A subsequent clean frame is received correctly. Assert `reset_n` mid-frame → all outputs 0.
